// File: rtl/rx_symbol_detector_pkg.sv
// Shared receiver definitions: FSM state encoding, datapath widths and the
// accumulator width helper used by the integrate-and-dump detector.
package rx_symbol_detector_pkg;

  localparam int SAMPLE_W   = 21;  // received sample width (unsigned)
  localparam int LOG2_SPS   = 3;   // log2 samples per symbol
  localparam int AMP_SHIFT  = 10;  // reference constant -> per-sample '1' amplitude
  localparam int NOISE_BIAS = 4;   // expected mean noise per sample
  localparam int ATTEN_W    = 5;   // attenuated reference constant width

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    DECIDE    = 2'd2
  } rx_state_e;

  // Summing 2**log2_sps samples of sample_w bits needs log2_sps extra bits,
  // so the accumulator can never overflow.
  function automatic int acc_width(input int sample_w, input int log2_sps);
    return sample_w + log2_sps;
  endfunction

endpackage

// File: rtl/rx_symbol_detector_if.sv
// Receiver bus: sample stream + reference constant in, decided bits and
// packed bytes (valid/ready) out.
//   master : channel/decoder side (drives samples, byte_ready)
//   slave  : detector side (drives bits, bytes, overrun)
interface rx_symbol_detector_if #(
  parameter int SAMPLE_W = rx_symbol_detector_pkg::SAMPLE_W
);
  import rx_symbol_detector_pkg::*;

  logic [SAMPLE_W-1:0] rx_sample;
  logic                rx_valid;
  logic [ATTEN_W-1:0]  atten_const;
  logic [7:0]          byte_data;
  logic                byte_valid;
  logic                byte_ready;
  logic                bit_out;
  logic                bit_strobe;
  logic                overrun;

  modport master (
    output rx_sample, rx_valid, atten_const, byte_ready,
    input  byte_data, byte_valid, bit_out, bit_strobe, overrun
  );

  modport slave (
    input  rx_sample, rx_valid, atten_const, byte_ready,
    output byte_data, byte_valid, bit_out, bit_strobe, overrun
  );

endinterface

// File: rtl/rx_symbol_detector_byte_packer.sv
// rx_byte_packer: packs decided bits LSB-first into bytes and holds each byte
// in an output register behind a valid/ready handshake.
//   clk, reset  : clock, synchronous active-high reset
//   bit_in      : decided bit, sampled when bit_strobe=1
//   bit_strobe  : one-cycle bit-decided enable
//   byte_ready  : downstream accepts when byte_valid && byte_ready
//   byte_data   : assembled byte
//   byte_valid  : byte_data valid, held until accepted
//   overrun     : sticky, a held byte was overwritten before acceptance
module rx_byte_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_strobe,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       overrun
);

  logic [2:0] idx;
  logic [7:0] shreg;
  logic [7:0] merged;

  // Shift register with the incoming bit already placed, so the 8th bit can
  // be loaded into the output register on the same edge it is decided.
  always_comb begin
    merged      = shreg;
    merged[idx] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (byte_valid && byte_ready) byte_valid <= 1'b0;
      if (bit_strobe) begin
        shreg <= merged;
        idx   <= idx + 3'd1;
        if (idx == 3'd7) begin
          // A completing byte always wins over the clear above; the old byte
          // is only lost if nobody is accepting it this cycle.
          byte_data  <= merged;
          byte_valid <= 1'b1;
          if (byte_valid && !byte_ready) overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rx_symbol_detector.sv
// rx_symbol_detector: integrate-and-dump OOK detector. Sums SPS valid samples
// per symbol, decides bit = sum > threshold (threshold latched from
// atten_const on the first sample of the symbol) and hands bits to the packer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of rx_symbol_detector_if (samples, atten_const,
//                byte handshake, bit_out/bit_strobe, overrun)
module rx_symbol_detector #(
  parameter int SAMPLE_W   = rx_symbol_detector_pkg::SAMPLE_W,
  parameter int LOG2_SPS   = rx_symbol_detector_pkg::LOG2_SPS,
  parameter int AMP_SHIFT  = rx_symbol_detector_pkg::AMP_SHIFT,
  parameter int NOISE_BIAS = rx_symbol_detector_pkg::NOISE_BIAS
) (
  input logic                  clk,
  input logic                  reset,
  rx_symbol_detector_if.slave  bus
);
  import rx_symbol_detector_pkg::*;

  localparam int SPS   = 1 << LOG2_SPS;
  localparam int ACC_W = acc_width(SAMPLE_W, LOG2_SPS);
  localparam int CNT_W = LOG2_SPS + 1;

  rx_state_e        state, state_nxt;
  logic [ACC_W-1:0] acc, thr, thr_new;
  logic [CNT_W-1:0] cnt;
  logic             load_first, accumulate, decide, last_sample, bit_dec;
  logic             bit_out_q, bit_strobe_q;

  assign last_sample = (cnt == CNT_W'(SPS - 1));
  assign thr_new     = (ACC_W'(bus.atten_const) << (AMP_SHIFT + LOG2_SPS - 1))
                     + ACC_W'(NOISE_BIAS * SPS);
  assign bit_dec     = (acc > thr);  // equality decides 0

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.rx_valid) state_nxt = INTEGRATE;
      INTEGRATE: if (bus.rx_valid && last_sample) state_nxt = DECIDE;
      DECIDE:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Control outputs; a sample offered during DECIDE matches none of them and
  // is dropped.
  always_comb begin
    load_first = 1'b0;
    accumulate = 1'b0;
    decide     = 1'b0;
    case (state)
      IDLE:      load_first = bus.rx_valid;
      INTEGRATE: accumulate = bus.rx_valid;
      DECIDE:    decide     = 1'b1;
      default:   ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      acc          <= '0;
      thr          <= '0;
      cnt          <= '0;
      bit_out_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
    end else begin
      bit_strobe_q <= decide;
      if (load_first) begin
        // First sample overwrites rather than adds, so nothing leaks between
        // symbols.
        acc <= ACC_W'(bus.rx_sample);
        thr <= thr_new;
        cnt <= CNT_W'(1);
      end else if (accumulate) begin
        acc <= acc + ACC_W'(bus.rx_sample);
        cnt <= cnt + CNT_W'(1);
      end else if (decide) begin
        acc       <= '0;
        cnt       <= '0;
        bit_out_q <= bit_dec;
      end
    end
  end

  assign bus.bit_out    = bit_out_q;
  assign bus.bit_strobe = bit_strobe_q;

  rx_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_dec),
    .bit_strobe (decide),
    .byte_ready (bus.byte_ready),
    .byte_data  (bus.byte_data),
    .byte_valid (bus.byte_valid),
    .overrun    (bus.overrun)
  );

endmodule

// File: tb/tb_rx_symbol_detector.sv
module tb_rx_symbol_detector;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic b;
    int   cyc;
  } bit_exp_t;

  bit_exp_t   bq[$];
  logic [7:0] byq[$];
  bit_exp_t   be;
  logic [7:0] bye;

  rx_symbol_detector_if bus ();

  rx_symbol_detector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every bit_strobe pops an expected bit and strobe
  // cycle; every accepted byte pops an expected byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.bit_strobe) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: bit_out %0b with no bit expected (cycle %0d)", bus.bit_out, cyc);
        end else begin
          be = bq.pop_front();
          check("bit_out", bus.bit_out, be.b);
          check("strobe_cycle", cyc, be.cyc);
        end
      end
      if (bus.byte_valid && bus.byte_ready) begin
        if (byq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: byte_data %0h with no byte expected (cycle %0d)", bus.byte_data, cyc);
        end else begin
          bye = byq.pop_front();
          check("byte_data", bus.byte_data, bye);
        end
      end
    end
  end

  // One symbol: 8 samples base + k*step (+extra on the last), gap idle cycles
  // between samples; atten_const switches to mid_atten after the first sample.
  // A junk sample is offered in the DECIDE cycle and must be dropped.
  task automatic send_sym(input int base, input int step, input int extra,
                          input int gap, input logic [4:0] mid_atten, input logic exp_b);
    int acc_cyc;
    bit_exp_t e;
    bus.atten_const = 5'd8;
    for (int k = 0; k < 8; k++) begin
      bus.rx_valid  = 1'b1;
      bus.rx_sample = 21'(base + k * step + ((k == 7) ? extra : 0));
      @(posedge clk); #1;
      if (k == 0) bus.atten_const = mid_atten;
      acc_cyc = cyc;
      if (k < 7 && gap > 0) begin
        bus.rx_valid  = 1'b0;
        bus.rx_sample = 21'h1FFFFF;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    e.b   = exp_b;
    e.cyc = acc_cyc + 1;
    bq.push_back(e);
    bus.atten_const = 5'd8;
    bus.rx_valid    = 1'b1;
    bus.rx_sample   = 21'h1FFFFF;
    @(posedge clk); #1;
    bus.rx_valid    = 1'b0;
    bus.rx_sample   = '0;
  endtask

  task automatic send_byte(input logic [7:0] val, input int gap);
    for (int i = 0; i < 8; i++)
      send_sym(val[i] ? 8192 : 0, 1, 0, gap, 5'd8, val[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_byte_data"},  bus.byte_data, 8'h00);
    check({tag, "_byte_valid"}, bus.byte_valid, 1'b0);
    check({tag, "_bit_out"},    bus.bit_out, 1'b0);
    check({tag, "_bit_strobe"}, bus.bit_strobe, 1'b0);
    check({tag, "_overrun"},    bus.overrun, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b1;
    bus.rx_valid    = 1'b0;
    bus.rx_sample   = '0;
    bus.atten_const = 5'd8;
    bus.byte_ready  = 1'b1;
    idle(3);
    check_reset_state("reset");
    reset = 1'b0;
    idle(2);

    // Scenarios 1-2 plus padding: bits 1,0,0,1,0,1,1,0 -> 0x69
    send_sym(8192, 1, 0, 0, 5'd8, 1'b1);   // 65564 > 32800
    send_sym(0,    1, 0, 0, 5'd8, 1'b0);   // 28
    send_sym(4100, 0, 0, 0, 5'd0, 1'b0);   // exactly 32800; mid-symbol atten change ignored
    send_sym(4100, 0, 1, 0, 5'd8, 1'b1);   // 32801
    byq.push_back(8'h69);
    send_sym(0,    0, 0, 0, 5'd8, 1'b0);
    send_sym(8192, 0, 0, 0, 5'd8, 1'b1);
    send_sym(8192, 0, 0, 0, 5'd8, 1'b1);
    send_sym(0,    0, 0, 0, 5'd8, 1'b0);
    idle(3);

    // Scenario 3: 0x4D with byte_ready=1
    byq.push_back(8'h4D);
    send_byte(8'h4D, 0);
    check("s3_overrun", bus.overrun, 1'b0);
    idle(3);
    check("s3_valid_cleared", bus.byte_valid, 1'b0);

    // Scenario 4: byte_ready=0 across 0x4D then 0xA5
    bus.byte_ready = 1'b0;
    send_byte(8'h4D, 0);
    check("s4_first_valid", bus.byte_valid, 1'b1);
    check("s4_first_data", bus.byte_data, 8'h4D);
    check("s4_first_overrun", bus.overrun, 1'b0);
    send_byte(8'hA5, 0);
    check("s4_data", bus.byte_data, 8'hA5);
    check("s4_valid", bus.byte_valid, 1'b1);
    check("s4_overrun", bus.overrun, 1'b1);
    idle(2);
    check("s4_data_held", bus.byte_data, 8'hA5);
    byq.push_back(8'hA5);
    bus.byte_ready = 1'b1;
    idle(1);
    bus.byte_ready = 1'b0;
    check("s4_valid_after_accept", bus.byte_valid, 1'b0);
    check("s4_overrun_sticky", bus.overrun, 1'b1);
    bus.byte_ready = 1'b1;
    idle(2);

    // Scenario 5: gapped rx_valid, one valid every 3 cycles
    byq.push_back(8'hB1);
    send_byte(8'hB1, 2);
    idle(3);

    // Scenario 6: reset mid-byte (3 bits) and mid-symbol (5 samples)
    send_sym(8192, 0, 0, 0, 5'd8, 1'b1);
    send_sym(8192, 0, 0, 0, 5'd8, 1'b1);
    send_sym(8192, 0, 0, 0, 5'd8, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bus.rx_valid  = 1'b1;
      bus.rx_sample = 21'd8192;
      idle(1);
    end
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    idle(1);
    check_reset_state("s6_reset");
    reset = 1'b0;
    idle(1);
    byq.push_back(8'hFF);
    send_byte(8'hFF, 0);
    check("s6_overrun", bus.overrun, 1'b0);
    idle(4);

    check("bit_queue_drained", bq.size(), 0);
    check("byte_queue_drained", byq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
